mips_memory: RTL
================

Name: mips_memory

Overview:
- Memory responder for the processor core's instruction-fetch and data-access interfaces.
- It services the instruction port (instr_addr → instr_in) and the data port (data_addr / data_out / data_rd_wr → data_in) from one word-organised storage array.
- Registered read latency is one cycle, which matches the core's fetch and writeback timing.
- It also clears the array after reset, accepts host program loading, and keeps sticky error flags for the bench.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, ≥2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- instr_addr  in  32  instruction fetch byte address
- instr_in  out  32  instruction word, registered
- data_addr  in  32  data byte address
- data_out  in  32  store data from core
- data_rd_wr  in  1  1 = read, 0 = write
- data_in  out  32  load data to core, registered
- ld_en  in  1  host load write strobe
- ld_addr  in  32  host load byte address
- ld_data  in  32  host load word
- ready  out  1  clear sequence complete
- err_range  out  1  sticky: out-of-range access
- err_align  out  1  sticky: misaligned access
- err_conflict  out  1  sticky: core write dropped

Behaviour:
- Reset (reset==0 at posedge):
  - instr_in=0, data_in=0, ready=0, all err_* = 0.
  - FSM → CLEAR, clear counter = 0.
  - Array contents are not reset directly.
  - Reset asserted mid-CLEAR restarts the clear sequence from word 0.
- FSM CLEAR:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - At counter == DEPTH_WORDS-1, writes that word and moves to READY next cycle. Clear takes exactly DEPTH_WORDS cycles after reset release.
  - While in CLEAR: ready=0, instr_in and data_in register 0, core writes and ld_en are ignored, no error flags update.
- FSM READY: ready=1; stays there until reset.
- Address decode (per port):
  - offset = addr − BASE_ADDR, 32-bit unsigned.
  - in_range = offset < DEPTH_WORDS*4.
  - aligned = addr[1:0]==0.
  - index = offset[log2(DEPTH_WORDS)+1:2].
- Instruction port (READY):
  - instr_in <= in_range ? word[index] : 0, where 0 is the SLL-zero NOP.
  - A misaligned address uses the truncated index and sets err_align.
  - Out of range sets err_range.
- Data read (READY, data_rd_wr==1):
  - data_in <= in_range ? word[index] : 0.
  - Out of range sets err_range; misaligned sets err_align.
- Data write (READY, data_rd_wr==0):
  - word[index] <= data_out only if in_range and aligned.
  - Otherwise the write is dropped and err_range or err_align is set.
  - data_in holds its previous value during write cycles.
- Host load (READY, ld_en==1):
  - word[index] <= ld_data if in_range and aligned, otherwise dropped.
  - Host load errors never set the core error flags.
- Simultaneous host load and core write in the same cycle:
  - The host load wins.
  - The core write is dropped entirely, even for a different index, and err_conflict is set.
- Read-during-write:
  - Either read port returns the old word; reads happen before writes.
  - The new value is visible from the next cycle.
- Sticky flags clear only on reset.

Decomposition:
- Package mips_mem_pkg:
  - enum MEM_STATE {CLEAR, READY}.
  - WORD_BYTES=4.
  - Localparam helper for the index width, log2(DEPTH_WORDS).
- Sub-module mips_mem_addr_decode:
  - Combinational; addr → index, in_range, aligned.
  - Instantiated three times: instruction, data, and load ports.

Test Plan (bench DEPTH_WORDS=16, BASE_ADDR=32'h100):
1. Release reset after pre-filling the array with X → ready rises exactly 16 cycles later; reads of 0x100..0x13C all return 0.
2. ld_en with 0x108 / 32'hDEADBEEF, then instr_addr=0x108 → instr_in=DEADBEEF one cycle later; data read of 0x108 returns the same value.
3. Core write data_addr=0x110, data_out=0x12345678, rd_wr=0, with instr_addr=0x110 in the same cycle → instr_in=old value (0); next-cycle read returns 0x12345678.
4. Data read of 0x140 (out of range) → data_in=0, err_range=1 and stays set; a write to 0x112 is dropped and sets err_align=1.
5. ld_en to 0x104 and core write to 0x10C in the same cycle → 0x104 updated, 0x10C unchanged, err_conflict=1.
6. Assert reset at clear counter=7, release → ready rises 16 cycles after release; all flags 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory responder.
// Provides the FSM state enum, word size and index-width helper.
package mips_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Word-index width for a power-of-two depth (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mips_mem_addr_decode.sv
// Byte-address decoder for one memory port.
// Ports: addr_i (byte address) -> index_o, in_range_o, aligned_o.
module mips_mem_addr_decode
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int unsigned IDX_W      = idx_width(DEPTH_WORDS)
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] index_o,
    output logic             in_range_o,
    output logic             aligned_o
);

    // Span compared in 33 bits so DEPTH_WORDS*4 cannot wrap.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

    logic [31:0] offset;

    assign offset     = addr_i - BASE_ADDR;
    assign in_range_o = {1'b0, offset} < SPAN;
    // BASE_ADDR is word aligned, so offset[1:0] equals addr_i[1:0].
    assign aligned_o  = (offset[1:0] == 2'b00);
    assign index_o    = offset[IDX_W+1:2];

endmodule

// File: rtl/mips_memory.sv
// Word-organised memory serving instruction fetch, data access and host load.
// Ports: clk, reset (sync, active-low); instr_addr->instr_in; data_addr,
// data_out, data_rd_wr->data_in; ld_en/ld_addr/ld_data host load;
// ready after clear; sticky err_range, err_align, err_conflict.
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_in,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_rd_wr,
    output logic [31:0] data_in,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ready,
    output logic        err_range,
    output logic        err_align,
    output logic        err_conflict
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    mem_state_e       state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic        err_range_q, err_range_d;
    logic        err_align_q, err_align_d;
    logic        err_conf_q, err_conf_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] i_idx, d_idx, l_idx;
    logic             i_in, d_in, l_in;
    logic             i_al, d_al, l_al;

    logic             is_ready;
    logic             core_wr;
    logic             host_ok;
    logic             core_ok;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [31:0]      wdata;

    mips_mem_addr_decode #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_dec_instr (
        .addr_i     (instr_addr),
        .index_o    (i_idx),
        .in_range_o (i_in),
        .aligned_o  (i_al)
    );

    mips_mem_addr_decode #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_dec_data (
        .addr_i     (data_addr),
        .index_o    (d_idx),
        .in_range_o (d_in),
        .aligned_o  (d_al)
    );

    mips_mem_addr_decode #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_dec_load (
        .addr_i     (ld_addr),
        .index_o    (l_idx),
        .in_range_o (l_in),
        .aligned_o  (l_al)
    );

    assign is_ready = (state_q == READY);
    assign core_wr  = is_ready & ~data_rd_wr;
    assign host_ok  = is_ready & ld_en & l_in & l_al;
    // A host load in the same cycle suppresses any core write.
    assign core_ok  = core_wr & ~ld_en & d_in & d_al;

    // Clear sequencer
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
        endcase
    end

    // Single write port: clear, host load, or core store.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        unique case (1'b1)
            !is_ready: begin
                we    = reset;
                waddr = clr_cnt_q;
            end
            host_ok: begin
                we    = 1'b1;
                waddr = l_idx;
                wdata = ld_data;
            end
            core_ok: begin
                we    = 1'b1;
                waddr = d_idx;
                wdata = data_out;
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

    // Read ports and sticky flags
    always_comb begin
        instr_d     = '0;
        data_d      = '0;
        err_range_d = err_range_q;
        err_align_d = err_align_q;
        err_conf_d  = err_conf_q;
        if (is_ready) begin
            instr_d = i_in ? mem_q[i_idx] : 32'h0;
            if (data_rd_wr) begin
                data_d = d_in ? mem_q[d_idx] : 32'h0;
            end else begin
                data_d = data_q;
            end
            err_range_d = err_range_q | ~i_in | ~d_in;
            err_align_d = err_align_q | ~i_al | ~d_al;
            err_conf_d  = err_conf_q | (core_wr & ld_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            instr_q     <= '0;
            data_q      <= '0;
            err_range_q <= 1'b0;
            err_align_q <= 1'b0;
            err_conf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            err_range_q <= err_range_d;
            err_align_q <= err_align_d;
            err_conf_q  <= err_conf_d;
        end
    end

    // Storage is not reset; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign instr_in     = instr_q;
    assign data_in      = data_q;
    assign ready        = is_ready;
    assign err_range    = err_range_q;
    assign err_align    = err_align_q;
    assign err_conflict = err_conf_q;

endmodule
